chaser_sequencer: RTL and testbench
===================================

Name: chaser_sequencer

Overview:
Command-driven controller that sequences the LED chaser datapath. It accepts a mode, speed and cycle-count command over a valid/ready handshake, then generates the LED pattern for that many complete pattern cycles. It supports pause and abort, and signals completion with a one-cycle `done` pulse. It sits between the board control logic and the LED pins, and owns `led_out`.

Parameters:
- WIDTH, 8, number of LEDs; legal range is WIDTH >= 2.
- PRESCALE, 4, base clocks per speed unit; legal range is PRESCALE >= 1.
- SPEED_W, 3, width of the speed field.

Ports:
- clk, input, 1, single clock; all logic is on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, a command is present.
- cmd_ready, output, 1, the block can accept a command; high only in IDLE.
- cmd_mode, input, 2, pattern mode: 0 = ROTL, 1 = ROTR, 2 = BOUNCE, 3 = BLINK.
- cmd_speed, input, SPEED_W, step period = PRESCALE*(cmd_speed+1) clocks.
- cmd_cycles, input, 8, number of full pattern cycles to run; 0 means run until abort.
- pause, input, 1, level-sensitive freeze.
- abort, input, 1, terminate the run immediately without a done pulse.
- led_out, output, WIDTH, LED drive.
- busy, output, 1, high in RUN and HOLD.
- done, output, 1, one-cycle pulse when the requested cycles complete.

Behaviour:
- Reset (async, any state): state = IDLE, led_out = 0, busy = 0, done = 0, cmd_ready = 1, all counters = 0. Reset mid-run discards the run.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - cmd_ready = 1, led_out = 0.
  - Accept when cmd_valid && cmd_ready at edge T. At T the block latches mode, period, cycles and loads the initial pattern, then moves to RUN.
  - From T+1: busy = 1, cmd_ready = 0.
  - abort and pause are ignored in IDLE.
- Initial pattern:
  - ROTL, ROTR, BOUNCE: only bit 0 set; BOUNCE direction = up.
  - BLINK: all ones.
- Step timer:
  - In RUN, tick increments each clock.
  - When tick == period-1, the pattern advances one step and tick resets to 0.
  - The first advance is visible at T+1+period.
  - tick is wide enough for PRESCALE*2^SPEED_W.
- Step rules:
  - ROTL: rotate left by 1, with bit WIDTH-1 wrapping to bit 0.
  - ROTR: rotate right by 1.
  - BOUNCE: shift in the current direction. Direction flips on the step that reaches bit WIDTH-1 (flips to down) or bit 0 (flips to up). No wrap.
  - BLINK: invert all bits.
- Steps per cycle: ROTL/ROTR = WIDTH; BOUNCE = 2*(WIDTH-1); BLINK = 2.
  - A step counter tracks position within the cycle.
  - On the advance completing a cycle, the pattern is back at its initial value.
- Cycle completion:
  - If cycles_rem == 1, go to DONE instead of showing the pattern: led_out = 0, done = 1 for exactly one cycle, then IDLE.
  - If cycles_rem > 1, decrement and continue.
  - If cycles == 0 (infinite), do not decrement and never go to DONE.
- HOLD:
  - In RUN with pause = 1: no tick increment or advance that cycle; next state = HOLD.
  - In HOLD, led_out, tick, step and cycle counters are frozen. When pause = 0, return to RUN; counting resumes from the frozen tick.
  - Pause wins over a coincident advance.
- Abort:
  - In RUN or HOLD, abort = 1 gives: next state IDLE, led_out = 0, busy = 0, no done pulse.
  - Abort has priority over pause, advance and completion.
  - abort in DONE is ignored; the done pulse still occurs.
- cmd_valid while busy: the command is not accepted (cmd_ready = 0); the requester holds it until IDLE.
- All outputs are registered.

Test Plan:
All scenarios use WIDTH=8, PRESCALE=2.
1. ROTL, speed=1 (period 4), cycles=1, accepted at T:
   - led_out = 0x01 during T+1..T+4, then 0x02, 0x04, … 0x80, each held 4 clocks.
   - done = 1 with led_out = 0 at T+33; cmd_ready = 1 at T+34.
2. BOUNCE, speed=0 (period 2), cycles=2:
   - Sequence 01, 02, …, 80, 40, …, 02 repeated twice (28 steps).
   - Single done pulse after the 28th step; no 0x01→0x80 wrap ever observed.
3. BLINK, speed=0, cycles=0:
   - led_out alternates FF/00 every 2 clocks for 100 clocks with no done.
   - Assert abort: led_out = 0, busy = 0 the next cycle, done stays 0.
4. ROTR, speed=3 (period 8), cycles=1:
   - Hold pause high for 20 clocks mid-step at led_out = 0x40.
   - led_out stays 0x40 and busy = 1 throughout.
   - After release, the remaining tick count completes; total run time from acceptance = 64 + 20 clocks before done.
5. Handshake and priority:
   - cmd_valid held high while busy: exactly one acceptance per IDLE visit.
   - pause and abort asserted in the same clock during RUN → IDLE next cycle.
   - Async rst_n low mid-run: led_out = 0 and cmd_ready = 1 immediately.

Source files
------------

// File: rtl/chaser_sequencer.sv
// LED chaser sequencer: accepts one mode/speed/cycle-count command, then drives
// the selected LED pattern for the requested number of full cycles, with pause and abort.
module chaser_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    parameter int SPEED_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic [7:0]         cmd_cycles,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   led_out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] M_ROTL   = 2'd0;
    localparam logic [1:0] M_ROTR   = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_BLINK  = 2'd3;

    localparam int PERIOD_MAX = PRESCALE * (2 ** SPEED_W);
    localparam int TICK_W     = $clog2(PERIOD_MAX + 1);
    localparam int STEP_W     = $clog2(2 * WIDTH);

    state_t              state;
    logic [1:0]          mode;
    logic [TICK_W-1:0]   period_m1;
    logic [TICK_W-1:0]   tick;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   last_step;
    logic [7:0]          cycles_rem;
    logic                dir_up;
    logic [WIDTH-1:0]    next_pat;
    logic                next_dir;

    assign state_dbg = state;

    always_comb begin
        last_step = STEP_W'(1);
        case (mode)
            M_ROTL, M_ROTR: last_step = STEP_W'(WIDTH - 1);
            M_BOUNCE:       last_step = STEP_W'(2 * WIDTH - 3);
            default:        last_step = STEP_W'(1);
        endcase
    end

    // Bounce turns around on the step that lands on an end bit, so it never wraps.
    always_comb begin
        next_pat = led_out;
        next_dir = dir_up;
        case (mode)
            M_ROTL: next_pat = {led_out[WIDTH-2:0], led_out[WIDTH-1]};
            M_ROTR: next_pat = {led_out[0], led_out[WIDTH-1:1]};
            M_BOUNCE: begin
                if (dir_up) begin
                    next_pat = led_out << 1;
                    if (next_pat[WIDTH-1]) next_dir = 1'b0;
                end else begin
                    next_pat = led_out >> 1;
                    if (next_pat[0]) next_dir = 1'b1;
                end
            end
            default: next_pat = ~led_out;
        endcase
    end

    // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so the requester holds the command until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= M_ROTL;
            period_m1  <= '0;
            tick       <= '0;
            step       <= '0;
            cycles_rem <= '0;
            dir_up     <= 1'b1;
            led_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode       <= cmd_mode;
                        period_m1  <= TICK_W'(PRESCALE * (int'(cmd_speed) + 1) - 1);
                        cycles_rem <= cmd_cycles;
                        tick       <= '0;
                        step       <= '0;
                        dir_up     <= 1'b1;
                        led_out    <= (cmd_mode == M_BLINK) ? {WIDTH{1'b1}} : WIDTH'(1);
                        busy       <= 1'b1;
                        cmd_ready  <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (abort) begin
                        led_out   <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (pause) begin
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                        if (tick == period_m1) begin
                            tick <= '0;
                            if (step == last_step) begin
                                step <= '0;
                                // cycles_rem of 0 means an endless run
                                if (cycles_rem == 8'd1) begin
                                    led_out <= '0;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                    state   <= DONE;
                                end else begin
                                    led_out <= next_pat;
                                    dir_up  <= next_dir;
                                    if (cycles_rem != 8'd0) cycles_rem <= cycles_rem - 8'd1;
                                end
                            end else begin
                                step    <= step + STEP_W'(1);
                                led_out <= next_pat;
                                dir_up  <= next_dir;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chaser_sequencer.sv
// Bench for chaser_sequencer: directed scenarios plus randomized commands, checked
// clock by clock against a pattern-index model of the LED sequence.
module tb_chaser_sequencer;

    localparam int W         = 8;
    localparam int PRESCALE  = 2;
    localparam int SPEED_W   = 3;
    localparam int RUN_LIMIT = 3000;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_mode;
    logic [SPEED_W-1:0] cmd_speed;
    logic [7:0]         cmd_cycles;
    logic               pause;
    logic               abort;
    logic [W-1:0]       led_out;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;

    int vectors;
    int miscompares;
    int acc_count;
    int exp_acc;

    chaser_sequencer #(.WIDTH(W), .PRESCALE(PRESCALE), .SPEED_W(SPEED_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_speed  (cmd_speed),
        .cmd_cycles (cmd_cycles),
        .pause      (pause),
        .abort      (abort),
        .led_out    (led_out),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) acc_count <= acc_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int steps_of(input logic [1:0] m);
        case (m)
            2'd0, 2'd1: return W;
            2'd2:       return 2 * (W - 1);
            default:    return 2;
        endcase
    endfunction

    // LED value k steps into a pattern cycle.
    function automatic logic [W-1:0] pat_at(input logic [1:0] m, input int k);
        case (m)
            2'd0:    return W'(1 << (k % W));
            2'd1:    return W'(1 << ((W - (k % W)) % W));
            2'd2:    return (k < W) ? W'(1 << k) : W'(1 << (2 * W - 2 - k));
            default: return (k % 2 == 0) ? {W{1'b1}} : {W{1'b0}};
        endcase
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE. edges counts
    // clock edges after the accepting edge up to the done/abort edge.
    task automatic run_cmd(input logic [1:0] m, input int speed, input int cycles,
                           input int pause_at, input int pause_len, input int abort_at,
                           input bit hold_valid, output int edges);
        int period, steps, total, elapsed, idx;
        bit ended, aborted, paused;
        period  = PRESCALE * (speed + 1);
        steps   = steps_of(m);
        total   = cycles * steps * period;
        edges   = 0;
        elapsed = 0;
        ended   = 1'b0;
        check("ready_idle", 32'(cmd_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("led_idle", 32'(led_out), 32'd0);
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_speed  = SPEED_W'(speed);
        cmd_cycles = 8'(cycles);
        exp_acc++;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) cmd_valid = 1'b0;
        while (!ended && edges < RUN_LIMIT) begin
            idx = (elapsed / period) % steps;
            check("led_run", 32'(led_out), 32'(pat_at(m, idx)));
            check("busy_run", 32'(busy), 32'd1);
            check("ready_run", 32'(cmd_ready), 32'd0);
            check("done_run", 32'(done), 32'd0);
            paused  = (edges >= pause_at) && (edges < pause_at + pause_len);
            aborted = (edges == abort_at);
            pause   = paused;
            abort   = aborted;
            @(posedge clk);
            edges++;
            @(negedge clk);
            pause = 1'b0;
            abort = 1'b0;
            if (aborted) begin
                check("led_abort", 32'(led_out), 32'd0);
                check("busy_abort", 32'(busy), 32'd0);
                check("done_abort", 32'(done), 32'd0);
                check("ready_abort", 32'(cmd_ready), 32'd1);
                ended = 1'b1;
            end else begin
                if (!paused) elapsed++;
                if (cycles != 0 && elapsed == total) begin
                    check("done_pulse", 32'(done), 32'd1);
                    check("led_done", 32'(led_out), 32'd0);
                    check("busy_done", 32'(busy), 32'd0);
                    check("ready_done", 32'(cmd_ready), 32'd0);
                    @(negedge clk);
                    check("done_single", 32'(done), 32'd0);
                    check("ready_after", 32'(cmd_ready), 32'd1);
                    ended = 1'b1;
                end
            end
        end
        check("run_ended", 32'(ended), 32'd1);
    endtask

    initial begin
        int e;
        int pa, pl, ab;
        vectors     = 0;
        miscompares = 0;
        acc_count   = 0;
        exp_acc     = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_mode    = 2'd0;
        cmd_speed   = '0;
        cmd_cycles  = 8'd0;
        pause       = 1'b0;
        abort       = 1'b0;

        #12;
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ROTL period 4, one cycle: done on the 32nd edge after acceptance
        run_cmd(2'd0, 1, 1, -1, 0, -1, 1'b0, e);
        check("rotl_latency", 32'(e), 32'd32);

        // BOUNCE period 2, two cycles of 14 steps
        run_cmd(2'd2, 0, 2, -1, 0, -1, 1'b0, e);
        check("bounce_latency", 32'(e), 32'd56);

        // BLINK endless, aborted after 100 clocks
        run_cmd(2'd3, 0, 0, -1, 0, 100, 1'b0, e);
        check("blink_abort_edge", 32'(e), 32'd101);

        // ROTR period 8 with a 20-clock pause while showing 0x40
        run_cmd(2'd1, 3, 1, 20, 20, -1, 1'b0, e);
        check("rotr_pause_latency", 32'(e), 32'd84);

        // cmd_valid held through a run: re-accepted only once IDLE returns
        run_cmd(2'd3, 0, 1, -1, 0, -1, 1'b1, e);
        run_cmd(2'd3, 0, 1, -1, 0, -1, 1'b0, e);
        check("held_valid_accepts", 32'(acc_count), 32'(exp_acc));

        // pause and abort in the same clock
        run_cmd(2'd0, 0, 1, 5, 3, 5, 1'b0, e);

        for (int i = 0; i < 8; i++) begin
            pa = $urandom_range(0, 60);
            pl = $urandom_range(0, 12);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : -1;
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(1, 3),
                    pa, pl, ab, 1'b0, e);
        end

        // asynchronous reset mid-run
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd0;
        cmd_speed  = '0;
        cmd_cycles = 8'd1;
        exp_acc++;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("busy_pre_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led_out), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(2'd1, 0, 1, 3, 4, -1, 1'b0, e);
        check("post_reset_latency", 32'(e), 32'd20);
        check("accept_total", 32'(acc_count), 32'(exp_acc));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
